// File: rtl/spi_mem_sequencer.sv
// rtl/spi_mem_sequencer.sv - turns single Wishbone word accesses into spi_top register programs
//
// Purpose: sits between the SERV ibus/dbus arbiter and an OpenCores spi_top. It is
// the only master on the spi_top register bus. Every CPU access becomes a complete
// SPI memory transaction: opcode, 24-bit address and optional write data are loaded
// into TX1/TX0, slave select is set, the transfer is started and polled to completion,
// and for reads the RX0 word is returned with its byte order fixed up.
//
// Ports:
//   clk, rst_n          shared clock, synchronous active-low reset (spi_top uses the same)
//   i_wb_adr/dat/sel/we CPU request fields, captured when the request is accepted
//   i_wb_cyc            CPU request, held until o_wb_ack
//   o_wb_rdt, o_wb_ack  CPU read data and one-cycle completion pulse
//   o_spi_adr/dat/sel/we/cyc  spi_top register bus master (cyc doubles as stb)
//   i_spi_dat, i_spi_ack      spi_top register read data and access acknowledge
//   o_busy              high whenever the sequencer is not idle

module spi_mem_sequencer #(
   parameter logic [15:0] DIVIDER = 16'h0000,
   parameter logic [7:0]  SS_MASK = 8'h01,
   parameter logic [7:0]  RD_CMD  = 8'h03,
   parameter logic [7:0]  WR_CMD  = 8'h02
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic [4:0]  o_spi_adr,
   output logic [31:0] o_spi_dat,
   output logic [3:0]  o_spi_sel,
   output logic        o_spi_we,
   output logic        o_spi_cyc,
   input  logic [31:0] i_spi_dat,
   input  logic        i_spi_ack,
   output logic        o_busy
);

   localparam logic [4:0] ADR_TX0  = 5'h00;
   localparam logic [4:0] ADR_TX1  = 5'h04;
   localparam logic [4:0] ADR_CTRL = 5'h10;
   localparam logic [4:0] ADR_DIV  = 5'h14;
   localparam logic [4:0] ADR_SS   = 5'h18;

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_TX1, S_TX0, S_SS, S_GO, S_POLL, S_RX, S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_spi_cyc;
   logic        w_cyc_nxt;
   logic        w_accept;
   logic [21:0] r_adr;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic        r_we;
   logic        r_live;
   logic        r_ack;
   logic [31:0] r_rdt;

   logic [1:0]  w_off;
   logic [1:0]  w_hi;
   logic [2:0]  w_n;
   logic [31:0] w_bswap;
   logic [31:0] w_d_raw;
   logic [31:0] w_mask;
   logic [31:0] w_d;
   logic [7:0]  w_cmd;
   logic [63:0] w_f64;
   logic [6:0]  w_len;
   logic [31:0] w_ctrl;
   logic [4:0]  w_adr;
   logic [31:0] w_dat;
   logic        w_we;
   logic        w_unused;

   assign w_unused = ^{i_wb_adr[31:24], i_wb_adr[1:0]};

   // Byte span of the captured lane mask; reads always move a whole word.
   always_comb begin
      w_off = 2'd0;
      w_hi  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (r_sel[i]) w_off = i[1:0];
      end
      for (int i = 0; i < 4; i++) begin
         if (r_sel[i]) w_hi = i[1:0];
      end
      if (!r_we) begin
         w_off = 2'd0;
         w_hi  = 2'd3;
      end
   end

   assign w_n     = {1'b0, w_hi} - {1'b0, w_off} + 3'd1;
   assign w_bswap = {r_dat[7:0], r_dat[15:8], r_dat[23:16], r_dat[31:24]};
   // Lane off moves to the top byte; lanes above the span are masked off.
   assign w_d_raw = w_bswap << {w_off, 3'b000};
   assign w_mask  = ~(32'hFFFF_FFFF >> {w_n, 3'b000});
   assign w_d     = r_we ? (w_d_raw & w_mask) : 32'h0;
   assign w_cmd   = r_we ? WR_CMD : RD_CMD;
   // Right-align the frame so the SPI transfer length is exactly 4+n bytes.
   assign w_f64   = {w_cmd, r_adr, w_off, w_d} >> {(3'd4 - w_n), 3'b000};
   assign w_len   = 7'd32 + {1'b0, w_n, 3'b000};
   assign w_ctrl  = {18'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, w_len};

   // Register access presented in each state.
   always_comb begin
      w_adr = 5'h00;
      w_dat = 32'h0;
      w_we  = 1'b0;
      case (r_state)
         S_INIT: begin w_adr = ADR_DIV;  w_dat = {16'h0, DIVIDER}; w_we = 1'b1; end
         S_TX1:  begin w_adr = ADR_TX1;  w_dat = w_f64[63:32];     w_we = 1'b1; end
         S_TX0:  begin w_adr = ADR_TX0;  w_dat = w_f64[31:0];      w_we = 1'b1; end
         S_SS:   begin w_adr = ADR_SS;   w_dat = {24'h0, SS_MASK}; w_we = 1'b1; end
         S_GO:   begin w_adr = ADR_CTRL; w_dat = w_ctrl;           w_we = 1'b1; end
         S_POLL: begin w_adr = ADR_CTRL; end
         S_RX:   begin w_adr = ADR_TX0;  end
         default: begin end
      endcase
   end

   // Next state. An access state whose cyc is low is in its one-cycle gap and
   // raises cyc next; an acked access drops cyc and moves on (POLL may stay).
   always_comb begin
      w_state_nxt = r_state;
      w_cyc_nxt   = r_spi_cyc;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_wb_cyc) begin
               w_accept = 1'b1;
               if (i_wb_we && (i_wb_sel == 4'h0)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_TX1;
                  w_cyc_nxt   = 1'b1;
               end
            end
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: begin
            if (!r_spi_cyc) begin
               w_cyc_nxt = 1'b1;
            end else if (i_spi_ack) begin
               w_cyc_nxt = 1'b0;
               case (r_state)
                  S_INIT: w_state_nxt = S_IDLE;
                  S_TX1:  w_state_nxt = S_TX0;
                  S_TX0:  w_state_nxt = S_SS;
                  S_SS:   w_state_nxt = S_GO;
                  S_GO:   w_state_nxt = S_POLL;
                  S_POLL: begin
                     if (i_spi_dat[8])  w_state_nxt = S_POLL;
                     else if (r_we)     w_state_nxt = S_DONE;
                     else               w_state_nxt = S_RX;
                  end
                  S_RX:   w_state_nxt = S_DONE;
                  default: w_state_nxt = S_IDLE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_INIT;
         r_spi_cyc <= 1'b0;
         r_adr     <= 22'h0;
         r_dat     <= 32'h0;
         r_sel     <= 4'h0;
         r_we      <= 1'b0;
         r_live    <= 1'b0;
         r_ack     <= 1'b0;
         r_rdt     <= 32'h0;
      end else begin
         r_state   <= w_state_nxt;
         r_spi_cyc <= w_cyc_nxt;
         if (w_accept) begin
            r_adr  <= i_wb_adr[23:2];
            r_dat  <= i_wb_dat;
            r_sel  <= i_wb_sel;
            r_we   <= i_wb_we;
            r_live <= 1'b1;
         end else if (!i_wb_cyc) begin
            // A request withdrawn mid-sequence still completes but is never acked.
            r_live <= 1'b0;
         end
         r_ack <= (w_state_nxt == S_DONE) && i_wb_cyc && (w_accept || r_live);
         if ((r_state == S_RX) && r_spi_cyc && i_spi_ack) begin
            r_rdt <= {i_spi_dat[7:0], i_spi_dat[15:8], i_spi_dat[23:16], i_spi_dat[31:24]};
         end
      end
   end

   assign o_spi_cyc = r_spi_cyc;
   assign o_spi_sel = r_spi_cyc ? 4'hF : 4'h0;
   assign o_spi_adr = r_spi_cyc ? w_adr : 5'h00;
   assign o_spi_dat = r_spi_cyc ? w_dat : 32'h0;
   assign o_spi_we  = r_spi_cyc & w_we;
   assign o_wb_ack  = r_ack;
   assign o_wb_rdt  = r_rdt;
   // Held low during reset so every output reads zero while rst_n is asserted.
   assign o_busy    = rst_n && (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// tb/tb_spi_mem_sequencer.sv - scoreboard bench for spi_mem_sequencer

module tb_spi_mem_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_wb_adr = 32'h0;
   logic [31:0] i_wb_dat = 32'h0;
   logic [3:0]  i_wb_sel = 4'h0;
   logic        i_wb_we = 1'b0;
   logic        i_wb_cyc = 1'b0;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;
   logic [4:0]  o_spi_adr;
   logic [31:0] o_spi_dat;
   logic [3:0]  o_spi_sel;
   logic        o_spi_we;
   logic        o_spi_cyc;
   logic [31:0] i_spi_dat;
   logic        i_spi_ack;
   logic        o_busy;

   spi_mem_sequencer #(
      .DIVIDER(16'h0000), .SS_MASK(8'h01), .RD_CMD(8'h03), .WR_CMD(8'h02)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
      .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc),
      .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
      .o_spi_adr(o_spi_adr), .o_spi_dat(o_spi_dat), .o_spi_sel(o_spi_sel),
      .o_spi_we(o_spi_we), .o_spi_cyc(o_spi_cyc),
      .i_spi_dat(i_spi_dat), .i_spi_ack(i_spi_ack),
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  adr;
      logic        we;
      logic [31:0] dat;
   } acc_t;

   acc_t        exp_q[$];
   logic [31:0] rsp_q[$];
   int          total = 0;
   int          bad = 0;
   int          poll_left = 0;
   logic [31:0] rx_word = 32'h0;
   logic [31:0] last_rdt = 32'h0;
   logic        saw_poll = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame: the transfer is the byte list opcode, addr[23:16], addr[15:8],
   // {addr[7:2],off}, then data lanes off..hi in lane order; TX1:TX0 holds the list
   // right-aligned. CTRL carries the bit length plus GO, Tx_NEG and ASS.
   function automatic void ref_frame(input logic [31:0] adr, input logic [31:0] dat,
                                     input logic [3:0] sel, input logic we,
                                     output logic [31:0] tx1, output logic [31:0] tx0,
                                     output logic [31:0] ctrl);
      int lo;
      int hi;
      logic [7:0]  bq[$];
      logic [63:0] f;
      logic [1:0]  off;
      lo = 0;
      hi = 3;
      if (we) begin
         lo = -1;
         for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
               if (lo < 0) lo = i;
               hi = i;
            end
         end
      end
      off = lo[1:0];
      bq.push_back(we ? 8'h02 : 8'h03);
      bq.push_back(adr[23:16]);
      bq.push_back(adr[15:8]);
      bq.push_back({adr[7:2], off});
      if (we) begin
         for (int i = lo; i <= hi; i++) bq.push_back(dat[8*i +: 8]);
      end else begin
         for (int i = 0; i < 4; i++) bq.push_back(8'h00);
      end
      f = 64'h0;
      foreach (bq[k]) f = (f << 8) | {56'h0, bq[k]};
      tx1  = f[63:32];
      tx0  = f[31:0];
      ctrl = 32'h2500 | (32 + 8 * (hi - lo + 1));
   endfunction

   function automatic acc_t mk(input logic [4:0] adr, input logic we, input logic [31:0] dat);
      acc_t a;
      a.adr = adr;
      a.we  = we;
      a.dat = dat;
      return a;
   endfunction

   task automatic expect_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input logic we, input int polls, input logic [31:0] rx,
                             input bit want_ack, input bit completes);
      logic [31:0] tx1, tx0, ctrl;
      poll_left = polls;
      rx_word   = rx;
      if (we && sel == 4'h0) begin
         if (want_ack) rsp_q.push_back(last_rdt);
         return;
      end
      ref_frame(adr, dat, sel, we, tx1, tx0, ctrl);
      exp_q.push_back(mk(5'h04, 1'b1, tx1));
      exp_q.push_back(mk(5'h00, 1'b1, tx0));
      exp_q.push_back(mk(5'h18, 1'b1, 32'h0000_0001));
      exp_q.push_back(mk(5'h10, 1'b1, ctrl));
      for (int p = 0; p <= polls; p++) exp_q.push_back(mk(5'h10, 1'b0, 32'h0));
      if (!we) begin
         exp_q.push_back(mk(5'h00, 1'b0, 32'h0));
         // First SPI byte (RX0[31:24]) belongs in CPU lane 0.
         if (completes) begin
            for (int k = 0; k < 4; k++) last_rdt[8*k +: 8] = rx[8*(3-k) +: 8];
         end
      end
      if (want_ack) rsp_q.push_back(last_rdt);
   endtask

   // spi_top register model and SPI-side monitor.
   initial begin : spi_slave
      logic        in_acc;
      int          wait_left;
      logic [4:0]  cur_adr;
      logic        cur_we;
      logic [31:0] cur_dat;
      logic [31:0] resp;
      logic        bsy;
      acc_t        e;
      in_acc = 1'b0;
      wait_left = 0;
      resp = 32'h0;
      cur_adr = 5'h0;
      cur_we = 1'b0;
      cur_dat = 32'h0;
      i_spi_ack = 1'b0;
      i_spi_dat = 32'h0;
      forever begin
         @(negedge clk);
         if (i_spi_ack) begin
            i_spi_ack = 1'b0;
            in_acc = 1'b0;
            i_spi_dat = $urandom;
            check("spi_gap_cyc", {31'h0, o_spi_cyc}, 32'h0);
         end else if (o_spi_cyc) begin
            if (!in_acc) begin
               in_acc = 1'b1;
               cur_adr = o_spi_adr;
               cur_we = o_spi_we;
               cur_dat = o_spi_dat;
               wait_left = $urandom_range(0, 2);
               check("spi_sel", {28'h0, o_spi_sel}, 32'hF);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL spi_unexpected: got adr=%h we=%b dat=%h, expected no access", o_spi_adr, o_spi_we, o_spi_dat);
               end else begin
                  e = exp_q.pop_front();
                  check("spi_adr", {27'h0, o_spi_adr}, {27'h0, e.adr});
                  check("spi_we", {31'h0, o_spi_we}, {31'h0, e.we});
                  if (e.we) check("spi_wdat", o_spi_dat, e.dat);
               end
               if (o_spi_adr == 5'h10 && !o_spi_we) begin
                  saw_poll = 1'b1;
                  bsy = (poll_left > 0);
                  if (bsy) poll_left--;
                  resp = ($urandom & ~32'h100) | {23'h0, bsy, 8'h00};
               end else if (o_spi_adr == 5'h00 && !o_spi_we) begin
                  resp = rx_word;
               end else begin
                  resp = $urandom;
               end
            end else begin
               check("spi_hold", {o_spi_adr, o_spi_we, 26'h0} ^ o_spi_dat, {cur_adr, cur_we, 26'h0} ^ cur_dat);
            end
            if (wait_left == 0) begin
               i_spi_ack = 1'b1;
               i_spi_dat = resp;
            end else begin
               wait_left--;
               i_spi_dat = $urandom;
            end
         end else begin
            in_acc = 1'b0;
            i_spi_dat = $urandom;
         end
      end
   end

   // CPU-side monitor.
   initial begin : wb_monitor
      forever begin
         @(negedge clk);
         if (o_wb_ack) begin
            if (rsp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wb_unexpected_ack: got ack rdt=%h, expected none", o_wb_rdt);
            end else begin
               check("wb_rdt", o_wb_rdt, rsp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (o_busy && n < 600);
      check({name, "_idle"}, {31'h0, o_busy}, 32'h0);
      check({name, "_drained"}, exp_q.size(), 32'h0);
   endtask

   task automatic drive(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we);
      @(posedge clk);
      #1;
      i_wb_adr = adr;
      i_wb_dat = dat;
      i_wb_sel = sel;
      i_wb_we  = we;
      i_wb_cyc = 1'b1;
   endtask

   task automatic do_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input int polls, input logic [31:0] rx);
      int  cyc_n;
      bit  got;
      expect_txn(adr, dat, sel, we, polls, rx, 1'b1, 1'b1);
      drive(adr, dat, sel, we);
      cyc_n = 0;
      got = 1'b0;
      while (!got && cyc_n < 400) begin
         @(negedge clk);
         cyc_n++;
         if (o_wb_ack) begin
            got = 1'b1;
         end else if (cyc_n == 2) begin
            // Request fields must have been captured at acceptance.
            i_wb_adr = $urandom;
            i_wb_dat = $urandom;
            i_wb_sel = 4'($urandom);
            i_wb_we  = 1'($urandom);
         end
      end
      check("wb_ack_seen", {31'h0, got}, 32'h1);
      if (we && sel == 4'h0) check("sel0_ack_latency_le2", {31'h0, cyc_n <= 2}, 32'h1);
      i_wb_cyc = 1'b0;
      wait_idle("txn");
   endtask

   task automatic wait_poll(input string name);
      int n;
      n = 0;
      saw_poll = 1'b0;
      while (!saw_poll && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_poll_reached"}, {31'h0, saw_poll}, 32'h1);
   endtask

   initial begin : stimulus
      logic [31:0] a, d, rx;
      logic [3:0]  s;
      logic        w;
      exp_q.push_back(mk(5'h14, 1'b1, 32'h0));
      repeat (2) begin
         @(negedge clk);
         check("rst_spi_cyc", {31'h0, o_spi_cyc}, 32'h0);
         check("rst_wb_ack", {31'h0, o_wb_ack}, 32'h0);
         check("rst_busy", {31'h0, o_busy}, 32'h0);
         check("rst_wb_rdt", o_wb_rdt, 32'h0);
         check("rst_spi_bus", {o_spi_adr, o_spi_we, o_spi_sel, 22'h0} | o_spi_dat, 32'h0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_idle("init");

      do_txn(32'h0012_3458, 32'h0, 4'hF, 1'b0, 3, 32'hAABB_CCDD);
      do_txn(32'h0000_0010, 32'h00EE_0000, 4'b0100, 1'b1, 1, 32'h0);
      do_txn(32'h0000_0020, 32'h1234_0000, 4'b1100, 1'b1, 0, 32'h0);
      do_txn(32'h0000_0040, 32'hDEAD_BEEF, 4'b0000, 1'b1, 0, 32'h0);
      do_txn(32'h00FF_FFFC, 32'h1122_3344, 4'b1001, 1'b1, 2, 32'h0);
      do_txn(32'hFF00_0007, 32'h0, 4'b0000, 1'b0, 0, 32'h0102_0304);

      // CPU withdraws during POLL: sequence finishes, RX still captured, no ack.
      expect_txn(32'h0000_1000, 32'h0, 4'hF, 1'b0, 3, 32'h5566_7788, 1'b0, 1'b1);
      drive(32'h0000_1000, 32'h0, 4'hF, 1'b0);
      wait_poll("abort");
      @(negedge clk);
      i_wb_cyc = 1'b0;
      wait_idle("abort");
      do_txn(32'h0000_2000, 32'h0000_00AB, 4'b0001, 1'b1, 0, 32'h0);

      // Reset pulsed during POLL.
      expect_txn(32'h0000_3000, 32'h0, 4'hF, 1'b0, 6, 32'h99AA_BBCC, 1'b0, 1'b0);
      drive(32'h0000_3000, 32'h0, 4'hF, 1'b0);
      wait_poll("rstpoll");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      i_wb_cyc = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      poll_left = 0;
      exp_q.push_back(mk(5'h14, 1'b1, 32'h0));
      last_rdt = 32'h0;
      rst_n = 1'b1;
      @(negedge clk);
      check("rstpoll_spi_cyc", {31'h0, o_spi_cyc}, 32'h0);
      wait_idle("rstpoll");

      for (int t = 0; t < 40; t++) begin
         a  = $urandom;
         d  = $urandom;
         s  = 4'($urandom);
         w  = 1'($urandom);
         rx = $urandom;
         do_txn(a, d, s, w, $urandom_range(0, 3), rx);
      end

      repeat (4) @(negedge clk);
      check("rsp_drained", rsp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
